// File: rtl/fnd_scan_ctrl_pkg.sv
// ============================================================================
//  Module   : fnd_scan_ctrl_pkg
//  Brief    : Shared types, constants and helpers for the FND digit scanner.
//  Revision : 1.0
// ============================================================================
`default_nettype none

package fnd_scan_ctrl_pkg;

    localparam int         c_FND_MAX_DIGITS = 8;
    localparam logic       c_COM_ON         = 1'b0;
    localparam logic [7:0] c_COM_ALL_OFF    = 8'hFF;

    typedef enum logic [1:0] {
        S_OFF  = 2'd0,
        S_SHOW = 2'd1,
        S_GAP  = 2'd2
    } scan_state_t;

    function automatic logic [2:0] next_sel(input logic [2:0] sel, input int num_digits);
        return (int'(sel) == num_digits - 1) ? 3'd0 : sel + 3'd1;
    endfunction

    // Common pattern for a lit slot; a masked digit keeps every common off.
    function automatic logic [7:0] com_decode(input logic [2:0] sel, input logic [7:0] mask);
        logic [7:0] com;
        com = c_COM_ALL_OFF;
        if (!mask[sel]) begin
            com[sel] = c_COM_ON;
        end
        return com;
    endfunction

endpackage

`default_nettype wire

// File: rtl/fnd_scan_ctrl_if.sv
// ============================================================================
//  Module   : fnd_scan_ctrl_if
//  Brief    : Control/display bundle between the scan controller and its user.
//  Revision : 1.0
// ============================================================================
`default_nettype none

interface fnd_scan_ctrl_if;

    logic       i_on;
    logic [7:0] i_blank_mask;
    logic [2:0] o_sel;
    logic [7:0] o_com;
    logic       o_tick;
    logic       o_frame;

    modport master (
        output i_on,
        output i_blank_mask,
        input  o_sel,
        input  o_com,
        input  o_tick,
        input  o_frame
    );

    modport slave (
        input  i_on,
        input  i_blank_mask,
        output o_sel,
        output o_com,
        output o_tick,
        output o_frame
    );

endinterface

`default_nettype wire

// File: rtl/fnd_scan_ctrl_tc_counter.sv
// ============================================================================
//  Module   : tc_counter
//  Brief    : Count-up slot counter with synchronous clear and terminal flag.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module tc_counter #(
    parameter int CNT_W = 17
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic             i_clr,
    input  wire logic             i_en,
    input  wire logic [CNT_W-1:0] i_term,
    output logic      [CNT_W-1:0] o_cnt,
    output logic                  o_tc
);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_en) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_cnt = r_cnt;
    assign o_tc  = (r_cnt == i_term);

endmodule

`default_nettype wire

// File: rtl/fnd_scan_ctrl.sv
// ============================================================================
//  Module   : fnd_scan_ctrl
//  Brief    : Time-multiplexed 7-segment digit scanner with inter-digit gap.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module fnd_scan_ctrl
    import fnd_scan_ctrl_pkg::*;
#(
    parameter int NUM_DIGITS  = 8,
    parameter int SHOW_CYCLES = 100000,
    parameter int GAP_CYCLES  = 1000,
    parameter int CNT_W       = 17
) (
    input  wire logic           i_clk,
    input  wire logic           i_reset,
    fnd_scan_ctrl_if.slave      bus
);

    localparam logic [CNT_W-1:0] c_SHOW_TERM = CNT_W'(SHOW_CYCLES - 1);
    localparam logic [CNT_W-1:0] c_GAP_TERM  = CNT_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
    localparam bit               c_HAS_GAP   = (GAP_CYCLES > 0);

    scan_state_t      r_state;
    logic [2:0]       r_sel;
    logic [7:0]       r_com;
    logic             r_tick;
    logic             r_frame;

    logic [CNT_W-1:0] w_cnt;
    logic [CNT_W-1:0] w_term;
    logic             w_tc;
    logic             w_clr;
    logic             w_en;
    logic [2:0]       w_sel_adv;

    // The one counter serves both slot phases; only the terminal value changes.
    assign w_term    = (r_state == S_GAP) ? c_GAP_TERM : c_SHOW_TERM;
    assign w_clr     = !bus.i_on || (r_state == S_OFF) || w_tc;
    assign w_en      = (r_state != S_OFF);
    assign w_sel_adv = next_sel(r_sel, NUM_DIGITS);

    tc_counter #(
        .CNT_W (CNT_W)
    ) u_slot_cnt (
        .clk    (i_clk),
        .rst    (i_reset),
        .i_clr  (w_clr),
        .i_en   (w_en),
        .i_term (w_term),
        .o_cnt  (w_cnt),
        .o_tc   (w_tc)
    );

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state <= S_OFF;
            r_sel   <= 3'd0;
            r_com   <= c_COM_ALL_OFF;
            r_tick  <= 1'b0;
            r_frame <= 1'b0;
        end else begin
            r_tick  <= 1'b0;
            r_frame <= 1'b0;
            if (!bus.i_on) begin
                r_state <= S_OFF;
                r_sel   <= 3'd0;
                r_com   <= c_COM_ALL_OFF;
            end else begin
                case (r_state)
                    S_OFF: begin
                        r_state <= S_SHOW;
                        r_sel   <= 3'd0;
                        r_com   <= com_decode(3'd0, bus.i_blank_mask);
                    end
                    S_SHOW: begin
                        if (w_tc && c_HAS_GAP) begin
                            r_state <= S_GAP;
                            r_com   <= c_COM_ALL_OFF;
                        end else if (w_tc) begin
                            // Gapless scan: step straight to the next digit.
                            r_sel   <= w_sel_adv;
                            r_tick  <= 1'b1;
                            r_frame <= (w_sel_adv == 3'd0);
                            r_com   <= com_decode(w_sel_adv, bus.i_blank_mask);
                        end else begin
                            r_com   <= com_decode(r_sel, bus.i_blank_mask);
                        end
                    end
                    S_GAP: begin
                        if (w_tc) begin
                            r_state <= S_SHOW;
                            r_sel   <= w_sel_adv;
                            r_tick  <= 1'b1;
                            r_frame <= (w_sel_adv == 3'd0);
                            r_com   <= com_decode(w_sel_adv, bus.i_blank_mask);
                        end else begin
                            r_com   <= c_COM_ALL_OFF;
                        end
                    end
                    default: begin
                        r_state <= S_OFF;
                        r_sel   <= 3'd0;
                        r_com   <= c_COM_ALL_OFF;
                    end
                endcase
            end
        end
    end

    assign bus.o_sel   = r_sel;
    assign bus.o_com   = r_com;
    assign bus.o_tick  = r_tick;
    assign bus.o_frame = r_frame;

endmodule

`default_nettype wire

// File: tb/tb_fnd_scan_ctrl.sv
// ============================================================================
//  Module   : tb_fnd_scan_ctrl
//  Brief    : Scoreboard bench for two scanner configurations (gapped, gapless).
//  Revision : 1.0
// ============================================================================
`default_nettype none

module tb_fnd_scan_ctrl;

    typedef struct packed {
        logic [2:0] sel;
        logic [7:0] com;
        logic       tick;
        logic       frame;
    } exp_t;

    localparam exp_t c_IDLE = '{sel: 3'd0, com: 8'hFF, tick: 1'b0, frame: 1'b0};

    logic       clk;
    logic       rst;
    logic       on;
    logic [7:0] mask;

    int checks   = 0;
    int failures = 0;

    exp_t qa[$];
    exp_t qb[$];

    fnd_scan_ctrl_if ifa();
    fnd_scan_ctrl_if ifb();

    assign ifa.i_on         = on;
    assign ifa.i_blank_mask = mask;
    assign ifb.i_on         = on;
    assign ifb.i_blank_mask = mask;

    fnd_scan_ctrl #(
        .NUM_DIGITS  (3),
        .SHOW_CYCLES (4),
        .GAP_CYCLES  (2),
        .CNT_W       (4)
    ) u_dut_a (
        .i_clk   (clk),
        .i_reset (rst),
        .bus     (ifa)
    );

    fnd_scan_ctrl #(
        .NUM_DIGITS  (8),
        .SHOW_CYCLES (4),
        .GAP_CYCLES  (0),
        .CNT_W       (4)
    ) u_dut_b (
        .i_clk   (clk),
        .i_reset (rst),
        .bus     (ifb)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // t counts clocks since the display was enabled; everything follows from it.
    function automatic exp_t predict(input int t, input int n, input int s, input int g,
                                     input logic [7:0] m);
        exp_t e;
        int   slot;
        int   digit;
        int   phase;
        slot    = s + g;
        digit   = (t / slot) % n;
        phase   = t % slot;
        e.sel   = 3'(digit);
        e.com   = 8'hFF;
        if (phase < s && !m[digit]) e.com[digit] = 1'b0;
        e.tick  = (t > 0) && (phase == 0);
        e.frame = e.tick && (digit == 0);
        return e;
    endfunction

    // Reference model: one expected output per clock, or an idle entry on reset.
    initial begin
        bit en_a = 0;
        bit en_b = 0;
        int t_a  = 0;
        int t_b  = 0;
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                qa.delete();
                qb.delete();
                en_a = 0;
                en_b = 0;
                qa.push_back(c_IDLE);
                qb.push_back(c_IDLE);
            end else begin
                if (!on) begin
                    en_a = 0;
                    en_b = 0;
                    qa.push_back(c_IDLE);
                    qb.push_back(c_IDLE);
                end else begin
                    if (!en_a) begin en_a = 1; t_a = 0; end else t_a++;
                    if (!en_b) begin en_b = 1; t_b = 0; end else t_b++;
                    qa.push_back(predict(t_a, 3, 4, 2, mask));
                    qb.push_back(predict(t_b, 8, 4, 0, mask));
                end
            end
        end
    end

    // Monitor: compare DUT outputs against the model on the falling edge.
    initial begin
        exp_t got;
        exp_t e;
        forever begin
            @(negedge clk);
            if (qa.size() > 0) begin
                e   = qa.pop_front();
                got = '{sel: ifa.o_sel, com: ifa.o_com, tick: ifa.o_tick, frame: ifa.o_frame};
                checks++;
                if (got !== e) begin
                    failures++;
                    $display("FAIL scan_a t=%0t got sel=%0d com=%h tick=%b frame=%b exp sel=%0d com=%h tick=%b frame=%b",
                             $time, got.sel, got.com, got.tick, got.frame, e.sel, e.com, e.tick, e.frame);
                end
            end
            if (qb.size() > 0) begin
                e   = qb.pop_front();
                got = '{sel: ifb.o_sel, com: ifb.o_com, tick: ifb.o_tick, frame: ifb.o_frame};
                checks++;
                if (got !== e) begin
                    failures++;
                    $display("FAIL scan_b t=%0t got sel=%0d com=%h tick=%b frame=%b exp sel=%0d com=%h tick=%b frame=%b",
                             $time, got.sel, got.com, got.tick, got.frame, e.sel, e.com, e.tick, e.frame);
                end
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    initial begin
        exp_t got_a;
        exp_t got_b;
        bit   found;
        rst  = 1'b1;
        on   = 1'b0;
        mask = 8'h00;
        cyc(3);
        rst = 1'b0;
        cyc(10);

        // Free-running scan over several frames of both configurations.
        on = 1'b1;
        cyc(70);

        // Blank digit 1 of every frame.
        mask = 8'h02;
        cyc(40);
        mask = 8'h00;
        cyc(7);

        // Drop enable mid-slot, then restart.
        on = 1'b0;
        cyc(3);
        on = 1'b1;
        cyc(9);

        // Asynchronous reset inside a gap of the gapped configuration.
        found = 0;
        for (int i = 0; i < 20; i++) begin
            if (ifa.o_com === 8'hFF && !found) found = 1;
            if (!found) cyc(1);
        end
        checks++;
        if (!found) begin
            failures++;
            $display("FAIL gap_wait got com=%h required FF within 20 clks", ifa.o_com);
        end
        rst = 1'b1;
        #1;
        got_a = '{sel: ifa.o_sel, com: ifa.o_com, tick: ifa.o_tick, frame: ifa.o_frame};
        got_b = '{sel: ifb.o_sel, com: ifb.o_com, tick: ifb.o_tick, frame: ifb.o_frame};
        checks++;
        if (got_a !== c_IDLE || got_b !== c_IDLE) begin
            failures++;
            $display("FAIL async_reset got a=%h b=%h required %h", got_a, got_b, c_IDLE);
        end
        cyc(2);
        rst = 1'b0;
        cyc(30);

        // Randomized enable and mask activity.
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 24) == 0) on = ~on;
            if ($urandom_range(0, 14) == 0) mask = 8'($urandom);
            cyc(1);
        end
        on = 1'b1;
        mask = 8'h00;
        cyc(40);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
